// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
// Cause encodings, FSM states and the default handler vector.
package exc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [3:0] EXC_NONE    = 4'b0000;
  localparam logic [3:0] EXC_IRQ     = 4'b0001;
  localparam logic [3:0] EXC_INVALID = 4'b0010;

  localparam logic [63:0] EXC_VECTOR_DEFAULT =
    64'h0000_0000_0000_00D8;

  // Reserved encodings behave exactly like EXC_NONE.
  function automatic logic is_cause(
    input logic [3:0] s
  );
    return (s == EXC_IRQ) || (s == EXC_INVALID);
  endfunction

endpackage

// File: rtl/exc_regs.sv
// Exception context registers: link address, syndrome, count.
// Loaded together on the exception entry edge.
module exc_regs
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [3:0]  cause,
  input  logic [63:0] pc,
  output logic [63:0] elr,
  output logic [3:0]  esr,
  output logic [7:0]  count
);

  logic [63:0] ret_addr;

  // An IRQ lets the current instruction retire; a fault squashes it.
  assign ret_addr = (cause == EXC_IRQ) ? pc + 64'd4 : pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elr   <= '0;
      esr   <= '0;
      count <= '0;
    end else if (load) begin
      elr   <= ret_addr;
      esr   <= cause;
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Two-state exception controller: entry, handler, ERET.
// Exc is combinational so fetch can redirect in the same cycle.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [63:0] VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  EStatus,
  input  logic        ERet,
  input  logic [63:0] PC,
  output logic        Exc,
  output logic [63:0] ExcVector,
  output logic        ExtIAck,
  output logic [63:0] ELR,
  output logic [3:0]  ESR,
  output logic        InHandler,
  output logic [7:0]  ExcCount
);

  state_t state;
  logic   take;

  // No nesting: causes only matter while idle.
  assign take      = (state == IDLE) && is_cause(EStatus);
  assign Exc       = take && !reset;
  assign ExcVector = VECTOR;
  assign InHandler = (state == HANDLER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ExtIAck <= 1'b0;
    end else begin
      ExtIAck <= take && (EStatus == EXC_IRQ);
      unique case (state)
        IDLE:    if (take) state <= HANDLER;
        HANDLER: if (ERet) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  exc_regs u_regs (
    .clk   (clk),
    .reset (reset),
    .load  (take),
    .cause (EStatus),
    .pc    (PC),
    .elr   (ELR),
    .esr   (ESR),
    .count (ExcCount)
  );

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter VECTOR, default 64'h0000_0000_0000_00D8, handler entry address driven on ExcVector.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 EStatus  input  4  cause from main decoder: 0000 none, 0001 external IRQ, 0010 invalid opcode, others reserved.
REQ-005 ERet  input  1  current instruction is ERET.
REQ-006 PC  input  64  address of current instruction.
REQ-007 Exc  output  1  redirect fetch to ExcVector this cycle.
REQ-008 ExcVector  output  64  constant VECTOR.
REQ-009 ExtIAck  output  1  one-cycle acknowledge to interrupting device.
REQ-010 ELR  output  64  exception link register (return address for ERET).
REQ-011 ESR  output  4  exception syndrome register (latched cause).
REQ-012 InHandler  output  1  high while in HANDLER state.
REQ-013 ExcCount  output  8  number of exceptions taken.

Function
REQ-014 Two states: IDLE, HANDLER; reset state IDLE.
REQ-015 IDLE with EStatus in {0001,0010}: Exc=1 combinationally same cycle; next edge -> HANDLER.
REQ-016 Entry edge latches ESR=EStatus; ELR=PC+4 for 0001 (instruction completes), ELR=PC for 0010 (instruction squashed).
REQ-017 PC+4 computed modulo 2^64; PC=64'hFFFF_FFFF_FFFF_FFFC yields ELR=0.
REQ-018 ExtIAck=1 exactly in the cycle after an 0001 entry edge, 0 otherwise.
REQ-019 Reserved EStatus values (0011-1111) treated as 0000: no Exc, no state change.
REQ-020 HANDLER: EStatus ignored (no nesting), Exc=0, ELR/ESR hold.
REQ-021 HANDLER with ERet=1: next edge -> IDLE; ELR/ESR hold their values.
REQ-022 HANDLER with ERet=1 and EStatus=0001 same cycle: ERET wins, IRQ masked; IRQ taken in IDLE only if EStatus still 0001.
REQ-023 IDLE with ERet=1 and EStatus=0000: no state change, no output change.
REQ-024 IDLE with ERet=1 and EStatus!=0000: exception taken per REQ-015/016.
REQ-025 ExcCount increments on every entry edge, wraps 8'hFF->8'h00.
REQ-026 InHandler=1 iff state is HANDLER.
REQ-027 ExcVector is constant VECTOR in all states, including reset.

Reset
REQ-028 reset asserted: state=IDLE, Exc=0, ExtIAck=0, ELR=0, ESR=0, ExcCount=0, InHandler=0, immediately and independent of clk.
REQ-029 Reset while in HANDLER discards the handler context; no ExtIAck pulse is issued for an entry interrupted by reset.
REQ-030 First edge after reset deasserts obeys REQ-015 against current inputs.

Structure
REQ-031 Shared package exc_pkg holds the state enum, EStatus cause constants (EXC_NONE, EXC_IRQ, EXC_INVALID) and the default VECTOR.
REQ-032 One sub-module, exc_regs, holds ELR/ESR/ExcCount with load enable; FSM and Exc/ExtIAck logic live in exception_ctrl.

Verification
REQ-033 IDLE, PC=0x100, EStatus=0010 -> Exc=1 same cycle; next edge ESR=0010, ELR=0x100, InHandler=1, ExtIAck=0, ExcCount=1.
REQ-034 IDLE, PC=0x200, EStatus=0001 -> Exc=1; next edge ELR=0x204, ESR=0001; ExtIAck=1 for exactly one cycle.
REQ-035 HANDLER, EStatus=0001 and ERet=1 same cycle -> Exc=0, next edge IDLE, ELR unchanged; EStatus held 0001 -> Exc=1 in IDLE cycle.
REQ-036 IDLE, EStatus=0101 or ERet=1 alone -> Exc=0, no state/register change.
REQ-037 256 exception/ERET round trips -> ExcCount returns to 0x00; PC=64'hFFFF_FFFF_FFFF_FFFC with 0001 -> ELR=0.
REQ-038 reset asserted mid-cycle while in HANDLER (no clk edge) -> all outputs to REQ-028 values immediately.
